// File: rtl/gpio_cfg_pkg.sv
// Shared types and default sizing for the GPIO pad configuration serial loader.
package gpio_cfg_pkg;

   localparam int unsigned GPIO_CFG_BITS = 13;
   localparam int unsigned GPIO_NPADS_1  = 19;
   localparam int unsigned GPIO_NPADS_2  = 19;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      LOAD_SETUP,
      LATCH,
      DONE
   } gpio_state_e;

   // One registered drive of the pad control chains.
   typedef struct packed {
      logic clock;
      logic load;
      logic resetn;
      logic data_1;
      logic data_2;
   } serial_drive_t;

endpackage

// File: rtl/gpio_serial_loader_if.sv
// Nets from housekeeping to the two user-area pad control serial chains.
interface gpio_serial_loader_if;

   logic serial_clock;
   logic serial_load;
   logic serial_resetn;
   logic serial_data_1;
   logic serial_data_2;

   modport master (
      output serial_clock,
      output serial_load,
      output serial_resetn,
      output serial_data_1,
      output serial_data_2
   );

   modport slave (
      input serial_clock,
      input serial_load,
      input serial_resetn,
      input serial_data_1,
      input serial_data_2
   );

endinterface

// File: rtl/gpio_serial_tick.sv
// Serial clock phase divider: strobes on the last wb_clk_i cycle of each phase.
module gpio_serial_tick #(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic wb_clk_i,
   input  logic wb_rst_i,
   input  logic clear,
   output logic phase_end_c
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign phase_end_c = (cnt == CNT_LAST);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || clear) begin
         cnt <= '0;
      end else if (phase_end_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/gpio_serial_loader.sv
// Shifts per-pad configuration words into both GPIO serial chains and strobes
// serial_load; a one-cycle registered bit-bang passthrough is kept for debug.
module gpio_serial_loader
   import gpio_cfg_pkg::*;
#(
   parameter int unsigned NPADS_1  = GPIO_NPADS_1,
   parameter int unsigned NPADS_2  = GPIO_NPADS_2,
   parameter int unsigned CFG_BITS = GPIO_CFG_BITS,
   parameter int unsigned CLK_DIV  = 1,
   parameter int unsigned IDXW     = $clog2(NPADS_1 + NPADS_2)
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                xfer_start,
   output logic [IDXW-1:0]     cfg_idx_1,
   output logic [IDXW-1:0]     cfg_idx_2,
   input  logic [CFG_BITS-1:0] cfg_data_1,
   input  logic [CFG_BITS-1:0] cfg_data_2,
   input  logic                bb_enable,
   input  logic                bb_clock,
   input  logic                bb_load,
   input  logic                bb_resetn,
   input  logic                bb_data_1,
   input  logic                bb_data_2,
   gpio_serial_loader_if.master ser,
   output logic                busy,
   output logic                xfer_done
);

   localparam int unsigned W     = (NPADS_1 > NPADS_2) ? NPADS_1 : NPADS_2;
   localparam int unsigned MSB   = CFG_BITS - 1;
   localparam int unsigned WCW   = (W > 1) ? $clog2(W) : 1;
   localparam int unsigned BCW   = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
   localparam int          PAD_1 = int'(W) - int'(NPADS_1);
   localparam int          PAD_2 = int'(W) - int'(NPADS_2);
   localparam logic [WCW-1:0] WORD_LAST = WCW'(W - 1);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(CFG_BITS - 1);

   gpio_state_e         state;
   serial_drive_t       drv;
   serial_drive_t       idle_drv_c;
   logic [CFG_BITS-1:0] sr_1;
   logic [CFG_BITS-1:0] sr_2;
   logic [CFG_BITS-1:0] sh_1_c;
   logic [CFG_BITS-1:0] sh_2_c;
   logic [CFG_BITS-1:0] fetch_1_c;
   logic [CFG_BITS-1:0] fetch_2_c;
   logic [BCW-1:0]      bit_cnt;
   logic [WCW-1:0]      word_cnt;
   int                  fetch_w_c;
   logic                phase_end_c;

   // Chain 1 is fed from its last pad down; leading pad words of the shorter chain are zeros.
   function automatic logic [IDXW-1:0] idx_1_of(input int w);
      int p;
      if (w < PAD_1) p = int'(NPADS_1) - 1;
      else if (w >= int'(W)) p = 0;
      else p = int'(W) - 1 - w;
      return IDXW'(p);
   endfunction

   function automatic logic [IDXW-1:0] idx_2_of(input int w);
      int p;
      if (w < PAD_2) p = int'(NPADS_1);
      else if (w >= int'(W)) p = int'(NPADS_1 + NPADS_2) - 1;
      else p = int'(NPADS_1) + w - PAD_2;
      return IDXW'(p);
   endfunction

   gpio_serial_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .clear       (state == IDLE),
      .phase_end_c (phase_end_c)
   );

   // Word being fetched this cycle and its pad-masked contents.
   always_comb begin
      fetch_w_c = (state == IDLE) ? 0 : int'(word_cnt) + 1;
      fetch_1_c = (fetch_w_c < PAD_1) ? '0 : cfg_data_1;
      fetch_2_c = (fetch_w_c < PAD_2) ? '0 : cfg_data_2;
      sh_1_c    = sr_1 << 1;
      sh_2_c    = sr_2 << 1;
   end

   always_comb begin
      idle_drv_c = '{clock: 1'b0, load: 1'b0, resetn: 1'b1, data_1: 1'b0, data_2: 1'b0};
      if (bb_enable) begin
         idle_drv_c = '{clock: bb_clock, load: bb_load, resetn: bb_resetn,
                        data_1: bb_data_1, data_2: bb_data_2};
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         drv       <= '0;
         busy      <= 1'b0;
         xfer_done <= 1'b0;
         cfg_idx_1 <= '0;
         cfg_idx_2 <= '0;
         sr_1      <= '0;
         sr_2      <= '0;
         bit_cnt   <= '0;
         word_cnt  <= '0;
      end else begin
         xfer_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (xfer_start && !bb_enable) begin
                  state     <= SHIFT_LO;
                  busy      <= 1'b1;
                  sr_1      <= fetch_1_c;
                  sr_2      <= fetch_2_c;
                  drv       <= '{clock: 1'b0, load: 1'b0, resetn: 1'b1,
                                 data_1: fetch_1_c[MSB], data_2: fetch_2_c[MSB]};
                  bit_cnt   <= '0;
                  word_cnt  <= '0;
                  cfg_idx_1 <= idx_1_of(1);
                  cfg_idx_2 <= idx_2_of(1);
               end else begin
                  drv       <= idle_drv_c;
                  cfg_idx_1 <= idx_1_of(0);
                  cfg_idx_2 <= idx_2_of(0);
               end
            end
            SHIFT_LO: begin
               if (phase_end_c) begin
                  state     <= SHIFT_HI;
                  drv.clock <= 1'b1;
               end
            end
            SHIFT_HI: begin
               if (phase_end_c) begin
                  drv.clock <= 1'b0;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     if (word_cnt == WORD_LAST) begin
                        state      <= LOAD_SETUP;
                        word_cnt   <= '0;
                        drv.data_1 <= 1'b0;
                        drv.data_2 <= 1'b0;
                     end else begin
                        // Next word was addressed one word ahead and is valid now.
                        state      <= SHIFT_LO;
                        word_cnt   <= word_cnt + WCW'(1);
                        sr_1       <= fetch_1_c;
                        sr_2       <= fetch_2_c;
                        drv.data_1 <= fetch_1_c[MSB];
                        drv.data_2 <= fetch_2_c[MSB];
                        cfg_idx_1  <= idx_1_of(int'(word_cnt) + 2);
                        cfg_idx_2  <= idx_2_of(int'(word_cnt) + 2);
                     end
                  end else begin
                     state      <= SHIFT_LO;
                     bit_cnt    <= bit_cnt + BCW'(1);
                     sr_1       <= sh_1_c;
                     sr_2       <= sh_2_c;
                     drv.data_1 <= sh_1_c[MSB];
                     drv.data_2 <= sh_2_c[MSB];
                  end
               end
            end
            LOAD_SETUP: begin
               if (phase_end_c) begin
                  state    <= LATCH;
                  drv.load <= 1'b1;
               end
            end
            LATCH: begin
               if (phase_end_c) begin
                  state     <= DONE;
                  drv.load  <= 1'b0;
                  busy      <= 1'b0;
                  xfer_done <= 1'b1;
               end
            end
            DONE: begin
               state     <= IDLE;
               drv       <= idle_drv_c;
               cfg_idx_1 <= idx_1_of(0);
               cfg_idx_2 <= idx_2_of(0);
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign ser.serial_clock  = drv.clock;
   assign ser.serial_load   = drv.load;
   assign ser.serial_resetn = drv.resetn;
   assign ser.serial_data_1 = drv.data_1;
   assign ser.serial_data_2 = drv.data_2;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Self-checking bench: default-size loader against a pad-chain shadow, plus a small padded config.
`timescale 1ns/1ps
module tb_gpio_serial_loader;

   localparam int unsigned A_N1 = 19, A_N2 = 19, A_CB = 13, A_IDXW = 6;
   localparam int unsigned A_LEN = A_N1 * A_CB;
   localparam int unsigned B_N1 = 3, B_N2 = 5, B_CB = 4, B_D = 2, B_IDXW = 3;

   logic wb_clk_i = 1'b0;
   logic wb_rst_i = 1'b1;
   logic bb_enable = 1'b0, bb_clock = 1'b0, bb_load = 1'b0, bb_resetn = 1'b0;
   logic bb_data_1 = 1'b0, bb_data_2 = 1'b0;
   logic a_start = 1'b0, b_start = 1'b0;

   logic [A_IDXW-1:0] a_idx_1, a_idx_2;
   logic [A_CB-1:0]   a_data_1, a_data_2;
   logic              a_busy, a_done;
   logic [B_IDXW-1:0] b_idx_1, b_idx_2;
   logic [B_CB-1:0]   b_data_1, b_data_2;
   logic              b_busy, b_done;
   logic [4:0]        a_ser;

   gpio_serial_loader_if ser_a ();
   gpio_serial_loader_if ser_b ();

   assign a_data_1 = 13'h1000 | 13'(a_idx_1);
   assign a_data_2 = 13'h1000 | 13'(a_idx_2);
   assign b_data_1 = 4'(b_idx_1) ^ 4'hA;
   assign b_data_2 = 4'(b_idx_2) ^ 4'hA;
   assign a_ser = {ser_a.serial_clock, ser_a.serial_load, ser_a.serial_resetn,
                   ser_a.serial_data_1, ser_a.serial_data_2};

   gpio_serial_loader #(.NPADS_1(A_N1), .NPADS_2(A_N2), .CFG_BITS(A_CB), .CLK_DIV(1)) dut_a (
      .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i), .xfer_start (a_start),
      .cfg_idx_1 (a_idx_1), .cfg_idx_2 (a_idx_2), .cfg_data_1 (a_data_1), .cfg_data_2 (a_data_2),
      .bb_enable (bb_enable), .bb_clock (bb_clock), .bb_load (bb_load), .bb_resetn (bb_resetn),
      .bb_data_1 (bb_data_1), .bb_data_2 (bb_data_2), .ser (ser_a),
      .busy (a_busy), .xfer_done (a_done));

   gpio_serial_loader #(.NPADS_1(B_N1), .NPADS_2(B_N2), .CFG_BITS(B_CB), .CLK_DIV(B_D)) dut_b (
      .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i), .xfer_start (b_start),
      .cfg_idx_1 (b_idx_1), .cfg_idx_2 (b_idx_2), .cfg_data_1 (b_data_1), .cfg_data_2 (b_data_2),
      .bb_enable (bb_enable), .bb_clock (bb_clock), .bb_load (bb_load), .bb_resetn (bb_resetn),
      .bb_data_1 (bb_data_1), .bb_data_2 (bb_data_2), .ser (ser_b),
      .busy (b_busy), .xfer_done (b_done));

   always #5 wb_clk_i = ~wb_clk_i;

   int cyc = 0;
   always @(posedge wb_clk_i) cyc <= cyc + 1;

   int unsigned n_checks = 0, n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Chain A shadow: bit 0 is the chain entry; pads shift away from it on each rising serial_clock.
   logic             mon_a = 1'b0, prev_clk_a = 1'b0;
   logic [A_LEN-1:0] sh_a1, sh_a2, lat_a1, lat_a2;
   int               t0_a, rel_a_m;
   int               a_busy_first, a_busy_last, a_load_first, a_load_last, a_load_cnt;
   int               a_done_cyc, a_done_cnt;
   logic [A_CB-1:0]  sb_a[$];

   always @(negedge wb_clk_i) begin
      if (mon_a) begin
         rel_a_m = cyc - t0_a;
         if (ser_a.serial_clock && !prev_clk_a) begin
            sh_a1 = {sh_a1[A_LEN-2:0], ser_a.serial_data_1};
            sh_a2 = {sh_a2[A_LEN-2:0], ser_a.serial_data_2};
         end
         if (ser_a.serial_load) begin
            lat_a1 = sh_a1;
            lat_a2 = sh_a2;
            a_load_cnt++;
            if (a_load_first < 0) a_load_first = rel_a_m;
            a_load_last = rel_a_m;
         end
         if (a_busy) begin
            if (a_busy_first < 0) a_busy_first = rel_a_m;
            a_busy_last = rel_a_m;
         end
         if (a_done) begin
            a_done_cnt++;
            a_done_cyc = rel_a_m;
         end
      end
      prev_clk_a = ser_a.serial_clock;
   end

   // Chain B: bit stream scoreboard plus cycle-exact waveform checks (N=20, D=2).
   logic mon_b = 1'b0, prev_clk_b = 1'b0;
   int   t0_b, rel_b_m;
   bit   qb1[$], qb2[$];

   always @(negedge wb_clk_i) begin
      if (mon_b) begin
         rel_b_m = cyc - t0_b;
         if (rel_b_m <= 86) begin
            check("b_busy", 32'(b_busy), 32'(rel_b_m >= 1 && rel_b_m <= 84));
            check("b_load", 32'(ser_b.serial_load), 32'(rel_b_m >= 83 && rel_b_m <= 84));
            check("b_done", 32'(b_done), 32'(rel_b_m == 85));
            if (rel_b_m >= 1 && rel_b_m <= 80)
               check("b_clk", 32'(ser_b.serial_clock), 32'(((rel_b_m - 1) / 2) % 2));
         end
         if (ser_b.serial_clock && !prev_clk_b) begin
            if (qb1.size() > 0 && qb2.size() > 0) begin
               check("b_bit_1", 32'(ser_b.serial_data_1), 32'(qb1.pop_front()));
               check("b_bit_2", 32'(ser_b.serial_data_2), 32'(qb2.pop_front()));
            end else begin
               check("b_extra_bit", 32'(qb1.size()), 32'd1);
            end
         end
      end
      prev_clk_b = ser_b.serial_clock;
   end

   task automatic reset_mon_a();
      a_busy_first = -1; a_busy_last = -1; a_load_first = -1; a_load_last = -1;
      a_load_cnt = 0; a_done_cyc = -1; a_done_cnt = 0;
      sh_a1 = '0; sh_a2 = '0; lat_a1 = '0; lat_a2 = '0;
   endtask

   task automatic run_a(input bit disturb);
      bit got_done;
      int rel;
      logic [A_CB-1:0] got, exp;
      reset_mon_a();
      for (int i = 0; i < int'(A_N1 + A_N2); i++) sb_a.push_back(13'h1000 | 13'(i));
      @(negedge wb_clk_i);
      a_start = 1'b1; t0_a = cyc; mon_a = 1'b1;
      @(negedge wb_clk_i);
      a_start = 1'b0;
      got_done = 1'b0;
      for (int k = 0; k < 2000 && !got_done; k++) begin
         @(negedge wb_clk_i);
         rel = cyc - t0_a;
         if (disturb && rel == 9) a_start = 1'b1;
         if (disturb && rel == 10) a_start = 1'b0;
         if (disturb && rel == 19) begin
            bb_enable = 1'b1; bb_clock = 1'b1; bb_load = 1'b0; bb_resetn = 1'b0;
            bb_data_1 = 1'b1; bb_data_2 = 1'b1;
         end
         if (a_done) got_done = 1'b1;
      end
      check("a_done_seen", 32'(got_done), 32'd1);
      @(negedge wb_clk_i);
      if (disturb) begin
         check("a_bb_after_done", 32'(a_ser), 32'(5'b10011));
         check("a_no_requeue", 32'(a_busy), 32'd0);
      end
      @(negedge wb_clk_i);
      mon_a = 1'b0;
      check("a_busy_first", a_busy_first, 32'd1);
      check("a_busy_last", a_busy_last, 32'd496);
      check("a_done_cyc", a_done_cyc, 32'd497);
      check("a_done_cnt", a_done_cnt, 32'd1);
      check("a_load_first", a_load_first, 32'd496);
      check("a_load_last", a_load_last, 32'd496);
      check("a_load_cnt", a_load_cnt, 32'd1);
      for (int p = 0; p < int'(A_N1 + A_N2); p++) begin
         exp = sb_a.pop_front();
         if (p < int'(A_N1)) got = lat_a1[p*A_CB +: A_CB];
         else got = lat_a2[(int'(A_N1 + A_N2) - 1 - p)*A_CB +: A_CB];
         check($sformatf("a_pad%0d", p), 32'(got), 32'(exp));
      end
      bb_enable = 1'b0; bb_clock = 1'b0; bb_load = 1'b0; bb_resetn = 1'b0;
      bb_data_1 = 1'b0; bb_data_2 = 1'b0;
   endtask

   task automatic run_b();
      logic [B_CB-1:0] w1, w2;
      for (int w = 0; w < 5; w++) begin
         w1 = (w < 2) ? 4'h0 : (4'(4 - w) ^ 4'hA);
         w2 = 4'(3 + w) ^ 4'hA;
         for (int b = int'(B_CB) - 1; b >= 0; b--) begin
            qb1.push_back(w1[b]);
            qb2.push_back(w2[b]);
         end
      end
      @(negedge wb_clk_i);
      b_start = 1'b1; t0_b = cyc; mon_b = 1'b1;
      @(negedge wb_clk_i);
      b_start = 1'b0;
      repeat (95) @(negedge wb_clk_i);
      mon_b = 1'b0;
      check("b_q1_left", 32'(qb1.size()), 32'd0);
      check("b_q2_left", 32'(qb2.size()), 32'd0);
   endtask

   task automatic bitbang();
      logic [4:0] pat;
      bb_enable = 1'b1;
      @(negedge wb_clk_i);
      for (int i = 0; i < 10; i++) begin
         pat = 5'($urandom_range(0, 31));
         {bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2} = pat;
         a_start = 1'(i % 2);
         @(negedge wb_clk_i);
         check("bb_pass", 32'(a_ser), 32'(pat));
         check("bb_busy", 32'(a_busy), 32'd0);
      end
      bb_enable = 1'b0; a_start = 1'b0;
      {bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2} = 5'b0;
      @(negedge wb_clk_i);
      check("bb_exit_idle", 32'(a_ser), 32'(5'b00100));
      check("bb_start_dropped", 32'(a_busy), 32'd0);
   endtask

   task automatic mid_reset();
      reset_mon_a();
      @(negedge wb_clk_i);
      a_start = 1'b1; t0_a = cyc; mon_a = 1'b1;
      @(negedge wb_clk_i);
      a_start = 1'b0;
      while (cyc - t0_a < 82) @(negedge wb_clk_i);
      check("mr_shift_hi", 32'(ser_a.serial_clock), 32'd1);
      check("mr_busy", 32'(a_busy), 32'd1);
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      check("mr_ser_reset", 32'(a_ser), 32'd0);
      check("mr_busy_reset", 32'(a_busy), 32'd0);
      check("mr_idx_reset", 32'({a_idx_1, a_idx_2}), 32'd0);
      wb_rst_i = 1'b0;
      repeat (600) @(negedge wb_clk_i);
      mon_a = 1'b0;
      check("mr_no_load", a_load_cnt, 32'd0);
      check("mr_no_done", a_done_cnt, 32'd0);
      check("mr_idle", 32'(a_ser), 32'(5'b00100));
   endtask

   initial begin
      wb_rst_i = 1'b1;
      bb_enable = 1'b1;
      {bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2} = 5'b11111;
      repeat (3) @(negedge wb_clk_i);
      check("rst_ser", 32'(a_ser), 32'd0);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_done", 32'(a_done), 32'd0);
      check("rst_idx", 32'({a_idx_1, a_idx_2}), 32'd0);
      wb_rst_i = 1'b0;
      bb_enable = 1'b0;
      {bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2} = 5'b0;
      @(negedge wb_clk_i);
      check("post_rst_resetn", 32'(ser_a.serial_resetn), 32'd1);
      check("post_rst_idle", 32'(a_ser), 32'(5'b00100));

      bitbang();
      run_a(1'b0);
      run_b();
      run_a(1'b1);
      mid_reset();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
